// File: rtl/lab2_proc_mul_div_iter.sv
// Iterative multiply/divide unit: one shift-add (MUL) or restoring shift-subtract
// (DIV/DIVU/REM) step per cycle, fixed latency regardless of operands.
module lab2_proc_mul_div_iter #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [1:0]         req_fn,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_msg
);

  localparam int unsigned CntW = $clog2(p_nbits + 1);

  localparam logic [1:0] FnMul  = 2'b00;
  localparam logic [1:0] FnDiv  = 2'b01;
  localparam logic [1:0] FnDivu = 2'b10;
  localparam logic [1:0] FnRem  = 2'b11;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q;
  logic [1:0]         fn_q;
  logic [p_nbits-1:0] a_q, b_q, acc_q;
  logic               qneg_q, rneg_q;

  logic               accept, last_step;
  logic               req_signed;
  logic [p_nbits-1:0] a_mag, b_mag;
  logic [p_nbits:0]   rem_sh, diff;
  logic [p_nbits-1:0] result;

  assign accept    = req_val && (state_q == StIdle);
  assign last_step = (cnt_q == CntW'(p_nbits - 1));

  assign req_signed = (req_fn == FnDiv) || (req_fn == FnRem);
  assign a_mag      = (req_signed && req_a[p_nbits-1]) ? (~req_a + 1'b1) : req_a;
  assign b_mag      = (req_signed && req_b[p_nbits-1]) ? (~req_b + 1'b1) : req_b;

  // Dividend bits shift out of a_q into the partial remainder; quotient bits shift into a_q.
  assign rem_sh = {acc_q, a_q[p_nbits-1]};
  assign diff   = rem_sh - {1'b0, b_q};

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_val)   state_d = StCalc;
      StCalc:  if (last_step) state_d = StDone;
      StDone:  if (resp_rdy)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      fn_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      fn_q   <= req_fn;
      acc_q  <= '0;
      a_q    <= (req_fn == FnMul) ? req_a : a_mag;
      b_q    <= (req_fn == FnMul) ? req_b : b_mag;
      // A zero divisor leaves the all-ones quotient un-negated.
      qneg_q <= req_signed && (req_a[p_nbits-1] ^ req_b[p_nbits-1]) && (req_b != '0);
      rneg_q <= req_signed && req_a[p_nbits-1];
    end else if (state_q == StCalc) begin
      cnt_q <= cnt_q + CntW'(1);
      if (fn_q == FnMul) begin
        acc_q <= acc_q + (b_q[0] ? a_q : '0);
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
      end else if (!diff[p_nbits]) begin
        acc_q <= diff[p_nbits-1:0];
        a_q   <= {a_q[p_nbits-2:0], 1'b1};
      end else begin
        acc_q <= rem_sh[p_nbits-1:0];
        a_q   <= {a_q[p_nbits-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    result = '0;
    unique case (fn_q)
      FnMul:   result = acc_q;
      FnDiv:   result = qneg_q ? (~a_q + 1'b1) : a_q;
      FnDivu:  result = a_q;
      FnRem:   result = rneg_q ? (~acc_q + 1'b1) : acc_q;
      default: result = '0;
    endcase
  end

  assign req_rdy  = (state_q == StIdle);
  assign resp_val = (state_q == StDone);
  assign resp_msg = (state_q == StDone) ? result : '0;

endmodule

// File: tb/tb_lab2_proc_mul_div_iter.sv
// Directed bench for lab2_proc_mul_div_iter (p_nbits = 32) with a short model-checked stream.
module tb_lab2_proc_mul_div_iter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_val = 1'b0;
  logic         req_rdy;
  logic [1:0]   req_fn = 2'b00;
  logic [N-1:0] req_a = '0;
  logic [N-1:0] req_b = '0;
  logic         resp_val;
  logic         resp_rdy = 1'b0;
  logic [N-1:0] resp_msg;

  int n_cmp = 0;
  int n_err = 0;

  lab2_proc_mul_div_iter #(.p_nbits(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_fn   (req_fn),
    .req_a    (req_a),
    .req_b    (req_b),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [1:0] fn, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (fn)
      2'b00:   return a * b;
      2'b01:   return (b == 0) ? '1 : ovf ? a : N'($signed(a) / $signed(b));
      2'b10:   return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : ovf ? '0 : N'($signed(a) % $signed(b));
    endcase
  endfunction

  // The accept cycle counts as cycle 0, so resp_val must first be seen in cycle N+1.
  task automatic do_op(input string tag, input logic [1:0] fn, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] exp, input int hold);
    int  lat;
    logic busy_bad;
    lat = 0;
    while (!req_rdy && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    req_val = 1'b1; req_fn = fn; req_a = a; req_b = b;
    resp_rdy = (hold == 0);
    @(posedge clk);
    #1;
    req_val = 1'b0; req_fn = 2'($urandom); req_a = $urandom; req_b = $urandom;
    lat = 0;
    busy_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!resp_val && (req_rdy || resp_msg != '0)) busy_bad = 1'b1;
    end while (!resp_val && lat < 100);
    check({tag, " latency"}, 64'(lat), 64'(N + 1));
    check({tag, " busy"}, 64'(busy_bad), 64'd0);
    check({tag, " result"}, 64'(resp_msg), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold"}, {62'd0, resp_val, req_rdy}, 64'b10);
      check({tag, " hold msg"}, 64'(resp_msg), 64'(exp));
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    resp_rdy = 1'b0;
    @(negedge clk);
    check({tag, " after"}, {31'd0, resp_val, req_rdy, resp_msg}, {31'd0, 1'b0, 1'b1, 32'd0});
  endtask

  initial begin
    logic        saw;
    logic [1:0]  fn;
    logic [N-1:0] a, b;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset state", {31'd0, req_rdy, resp_val, resp_msg}, {31'd0, 1'b1, 1'b0, 32'd0});

    do_op("mul neg",   2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    do_op("div neg",   2'b01, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
    do_op("rem neg",   2'b11, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
    do_op("divu",      2'b10, 32'd100,        32'd7,         32'd14,        0);
    do_op("div by 0",  2'b01, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    do_op("div -8/0",  2'b01, 32'hFFFF_FFF8,  32'd0,         32'hFFFF_FFFF, 0);
    do_op("rem by 0",  2'b11, 32'd5,          32'd0,         32'd5,         0);
    do_op("rem -7/0",  2'b11, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 0);
    do_op("divu by 0", 2'b10, 32'd9,          32'd0,         32'hFFFF_FFFF, 0);
    do_op("div ovf",   2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("rem ovf",   2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
    do_op("rem -7/-2", 2'b11, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    do_op("div -7/-2", 2'b01, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         0);
    do_op("divu big",  2'b10, 32'hFFFF_FFFF,  32'd16,        32'h0FFF_FFFF, 1);
    do_op("mul stall", 2'b00, 32'd3,          32'd4,         32'd12,        5);

    // Reset in the middle of a divide aborts it.
    req_val = 1'b1; req_fn = 2'b01; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk);
    #1 req_val = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort state", {31'd0, req_rdy, resp_val, resp_msg}, {31'd0, 1'b1, 1'b0, 32'd0});
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_val) saw = 1'b1;
    end
    check("abort no resp", 64'(saw), 64'd0);
    do_op("mul post", 2'b00, 32'd6, 32'd7, 32'd42, 0);

    // Reset wins over a simultaneous request.
    reset = 1'b1; req_val = 1'b1; req_fn = 2'b00; req_a = 32'd1; req_b = 32'd1;
    @(posedge clk);
    #1 reset = 1'b0; req_val = 1'b0;
    @(negedge clk);
    check("rst prio rdy", {62'd0, req_rdy, resp_val}, 64'b10);
    repeat (3) @(negedge clk);
    check("rst prio idle", {62'd0, req_rdy, resp_val}, 64'b10);

    for (int i = 0; i < 30; i++) begin
      fn = 2'($urandom_range(0, 3));
      a  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      case (i % 5)
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = 32'($urandom);
      endcase
      if (i % 7 == 0) a = 32'h8000_0000;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op($sformatf("rand%0d", i), fn, a, b, model(fn, a, b), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
